// File: rtl/dat_mem_arbiter.sv
// dat_mem_arbiter
// Shares the single-port data memory between the core load/store path and a
// host/debug port. The core normally wins a conflict. A bounded-wait counter
// forces a host grant after MAX_WAIT lost conflict cycles, which stalls the
// core for that one cycle. Every host access returns a one-cycle host_ack
// pulse, and host_rdata is registered.
//
// Optional feature macro: DMA_ARB_STATS_EN
//   When defined, the block adds saturating stall_cnt and host_cnt outputs.
//   When undefined, neither port nor counter exists.

module dat_mem_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic [DW-1:0] core_rdata,
  output logic          core_stall,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic [DW-1:0] host_rdata,
  output logic          host_ack,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_dat_in,
  input  logic [DW-1:0] mem_dat_out
`ifdef DMA_ARB_STATS_EN
  ,
  output logic [15:0]   stall_cnt,
  output logic [15:0]   host_cnt
`endif
);

  // MAX_WAIT of 0 still needs a one-bit counter so that the vector stays legal.
  localparam int WCW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [WCW-1:0] WAIT_LIMIT = WCW'(MAX_WAIT);

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_t;

  state_t         state;
  state_t         next_state;
  logic [WCW-1:0] wait_cnt;
  logic           host_gnt;
  logic           core_gnt;

  // Grant decision: the core wins unless the host has already lost MAX_WAIT conflicts.
  always_comb begin
    host_gnt = (state == IDLE) && host_req && (!core_req || (wait_cnt == WAIT_LIMIT));
    core_gnt = core_req && !host_gnt;
  end

  assign core_stall = core_req && host_gnt;
  assign core_rdata = mem_dat_out;

  // Memory port mux. When the port is idle, it parks on the core fields with writes disabled.
  always_comb begin
    mem_wr_en  = 1'b0;
    mem_addr   = core_addr;
    mem_dat_in = core_wdata;
    if (host_gnt) begin
      mem_wr_en  = host_we;
      mem_addr   = host_addr;
      mem_dat_in = host_wdata;
    end else if (core_gnt) begin
      mem_wr_en  = core_we;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state: a host grant always spends exactly one cycle in ACK.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (host_gnt) next_state = ACK;
      ACK:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // FSM outputs: the ack pulse is the ACK state itself.
  always_comb begin
    host_ack = (state == ACK);
  end

  // Count the conflict cycles the host has lost. The count freezes in ACK.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (state == IDLE) begin
      if (host_gnt || !host_req) begin
        wait_cnt <= '0;
      end else if (core_req && (wait_cnt != WAIT_LIMIT)) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  // Capture the host read data on the grant edge so that it is stable while host_ack is high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      host_rdata <= '0;
    end else if (host_gnt) begin
      host_rdata <= mem_dat_out;
    end
  end

`ifdef DMA_ARB_STATS_EN
  // Saturating activity counters: core stall cycles and completed host accesses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      host_cnt  <= '0;
    end else begin
      if (core_stall && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
      if (host_ack && (host_cnt != 16'hFFFF))    host_cnt  <= host_cnt + 16'd1;
    end
  end
`endif

endmodule
